// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the sequence playback slice:
//   - seq_state_t : playback FSM state encoding
//   - SEQ_ADDR_W / SEQ_DATA_W / SEQ_DEPTH : sequence RAM geometry
//   - SEQ_ON_CYCLES_DEF / SEQ_GAP_CYCLES_DEF : default display timing
//   - seq_max3() : helper used to size the dwell timer
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHOW  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    localparam int SEQ_ADDR_W = 5;
    localparam int SEQ_DATA_W = 4;
    localparam int SEQ_DEPTH  = 32;

    localparam int SEQ_ON_CYCLES_DEF  = 25000000;
    localparam int SEQ_GAP_CYCLES_DEF = 12500000;

    function automatic int seq_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Loadable down-counter used for every dwell period of the playback FSM.
// Loading value N-1 gives a dwell of N cycles: 'zero' is seen in the N-th
// cycle after the load edge. The counter parks at zero when not reloaded.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active-low (clears the count)
//   load     in   load load_val at the next edge
//   load_val in   W-bit reload value
//   zero     out  count is zero
// -----------------------------------------------------------------------------
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_player.sv
// -----------------------------------------------------------------------------
// seq_player
// Plays back the first 'level' symbols of the sequence RAM in address order.
// Each step fetches one symbol (RD_LAT+1 cycles), shows it for ON_CYCLES with
// show_valid high, then optionally blanks for GAP_CYCLES. 'finish' pulses
// once after the last step.
//
// Configuration macro:
//   SEQ_PLAYER_GAP_EN  defined   -> GAP state present (blank after each symbol)
//                      undefined -> SHOW goes straight to the next FETCH/DONE
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-low
//   start      in   begin playback (sampled in IDLE only)
//   level      in   number of symbols 0..32 (clamped), sampled with start
//   ram_addr   out  RAM read address
//   ram_q      in   RAM read data, valid RD_LAT cycles after ram_addr
//   show_valid out  symbol on show_data is to be displayed
//   show_data  out  current symbol (held between captures)
//   busy       out  high in every state except IDLE
//   finish     out  one-cycle pulse at end of playback
// -----------------------------------------------------------------------------
module seq_player
    import seq_pkg::*;
#(
    parameter int ADDR_W     = SEQ_ADDR_W,
    parameter int DATA_W     = SEQ_DATA_W,
    parameter int RD_LAT     = 2,
    parameter int ON_CYCLES  = SEQ_ON_CYCLES_DEF,
    parameter int GAP_CYCLES = SEQ_GAP_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   level,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic              show_valid,
    output logic [DATA_W-1:0] show_data,
    output logic              busy,
    output logic              finish
);

    localparam int TMR_W = $clog2(seq_max3(ON_CYCLES, GAP_CYCLES, RD_LAT + 1) + 1);
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(2 ** ADDR_W);

    seq_state_t         state;
    logic [ADDR_W:0]    len;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;
    logic               last_step;
    logic [ADDR_W:0]    start_len;

    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] lvl);
        return (lvl > MAX_LEN) ? MAX_LEN : lvl;
    endfunction

    assign start_len = clamp_len(level);
    // len is never zero outside IDLE/DONE, so len-1 cannot underflow here.
    assign last_step = ({1'b0, ram_addr} == (len - 1'b1));

    seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // The timer is reloaded on the same edge that enters the next dwell
    // state, so each load value is (dwell length - 1).
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            S_IDLE: begin
                tmr_load = start;
                tmr_val  = TMR_W'(RD_LAT);
            end
            S_FETCH: begin
                tmr_load = tmr_zero;
                tmr_val  = TMR_W'(ON_CYCLES - 1);
            end
            S_SHOW: begin
                tmr_load = tmr_zero;
`ifdef SEQ_PLAYER_GAP_EN
                tmr_val  = TMR_W'(GAP_CYCLES - 1);
`else
                tmr_val  = TMR_W'(RD_LAT);
`endif
            end
`ifdef SEQ_PLAYER_GAP_EN
            S_GAP: begin
                tmr_load = tmr_zero;
                tmr_val  = TMR_W'(RD_LAT);
            end
`endif
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            len        <= '0;
            ram_addr   <= '0;
            show_data  <= '0;
            show_valid <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len      <= start_len;
                        ram_addr <= '0;
                        busy     <= 1'b1;
                        if (start_len == '0) begin
                            state  <= S_DONE;
                            finish <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (tmr_zero) begin
                        show_data  <= ram_q;
                        show_valid <= 1'b1;
                        state      <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (tmr_zero) begin
                        show_valid <= 1'b0;
`ifdef SEQ_PLAYER_GAP_EN
                        state <= S_GAP;
`else
                        if (last_step) begin
                            state  <= S_DONE;
                            finish <= 1'b1;
                        end else begin
                            ram_addr <= ram_addr + 1'b1;
                            state    <= S_FETCH;
                        end
`endif
                    end
                end
`ifdef SEQ_PLAYER_GAP_EN
                S_GAP: begin
                    if (tmr_zero) begin
                        if (last_step) begin
                            state  <= S_DONE;
                            finish <= 1'b1;
                        end else begin
                            ram_addr <= ram_addr + 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
`endif
                S_DONE: begin
                    ram_addr <= '0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_player.sv
// -----------------------------------------------------------------------------
// tb_seq_player
// Directed and randomized playback runs of seq_player against a timeline
// model computed from the step period, with a small RAM model (latency 2).
// -----------------------------------------------------------------------------
module tb_seq_player;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int RD_LAT = 2;
    localparam int ON     = 4;
    localparam int GAP    = 2;
`ifdef SEQ_PLAYER_GAP_EN
    localparam int GAP_M  = GAP;
`else
    localparam int GAP_M  = 0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   level;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;
    logic              show_valid;
    logic [DATA_W-1:0] show_data;
    logic              busy;
    logic              finish;

    logic [DATA_W-1:0] mem [32];
    logic [DATA_W-1:0] rd_p0;
    logic [DATA_W-1:0] rd_p1;

    int n_assert = 0;
    int n_fail   = 0;

    seq_player #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .level      (level),
        .ram_addr   (ram_addr),
        .ram_q      (ram_q),
        .show_valid (show_valid),
        .show_data  (show_data),
        .busy       (busy),
        .finish     (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // two-stage read pipeline: data for ram_addr appears RD_LAT=2 cycles later
    always @(posedge clk) begin
        rd_p0 <= mem[ram_addr];
        rd_p1 <= rd_p0;
    end
    assign ram_q = rd_p1;

    task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag, input int t);
        check({tag, "_addr"},  t, 32'(ram_addr),   32'd0);
        check({tag, "_data"},  t, 32'(show_data),  32'd0);
        check({tag, "_valid"}, t, 32'(show_valid), 32'd0);
        check({tag, "_busy"},  t, 32'(busy),       32'd0);
        check({tag, "_fin"},   t, 32'(finish),     32'd0);
    endtask

    // One playback run. restart_t>0: pulse start again in that cycle.
    // rst_t>0: assert reset in that cycle, check the reset state next cycle.
    task automatic play(input int lvl, input int restart_t, input int rst_t);
        int L, P, total, s, off, cap;
        logic eb, ef, ev;
        L     = (lvl > 32) ? 32 : lvl;
        P     = (RD_LAT + 1) + ON + GAP_M;
        total = (L == 0) ? 3 : L * P + 3;
        level = 6'(lvl);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 1; t <= total; t++) begin
            if (rst_t > 0 && t == rst_t + 1) begin
                check_idle_zero("rst_mid", t);
                rst = 1'b1;
                @(posedge clk); #1;
                check("rst_mid_after_busy", t + 1, 32'(busy), 32'd0);
                return;
            end
            if (L == 0) begin
                eb = (t == 1); ef = (t == 1); ev = 1'b0; s = 0; cap = -1;
            end else if (t - 1 < L * P) begin
                s   = (t - 1) / P;
                off = (t - 1) % P;
                eb  = 1'b1; ef = 1'b0;
                ev  = (off > RD_LAT) && (off <= RD_LAT + ON);
                cap = (off > RD_LAT) ? s : s - 1;
            end else if (t - 1 == L * P) begin
                eb = 1'b1; ef = 1'b1; ev = 1'b0; s = -1; cap = L - 1;
            end else begin
                eb = 1'b0; ef = 1'b0; ev = 1'b0; s = 0; cap = L - 1;
            end
            check("busy",   t, 32'(busy),       32'(eb));
            check("finish", t, 32'(finish),     32'(ef));
            check("valid",  t, 32'(show_valid), 32'(ev));
            if (cap >= 0) check("data", t, 32'(show_data), 32'(mem[cap]));
            if (s >= 0)   check("addr", t, 32'(ram_addr),  32'(s));
            start = (t == restart_t);
            if (t == rst_t) rst = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int P;
        P     = (RD_LAT + 1) + ON + GAP_M;
        rst   = 1'b0;
        start = 1'b0;
        level = '0;
        for (int i = 0; i < 32; i++) mem[i] = 4'(i) ^ 4'hA;

        // reset state, with start held high to confirm it is ignored in reset
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset", 0);
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;

        play(3, 0, 0);                    // basic playback
        play(0, 0, 0);                    // zero level
        play(40, 0, 0);                   // clamp to 32, full length
        play(1, 0, 0);                    // single step
        play(3, RD_LAT + 3, 0);           // start re-pulsed during first SHOW
        play(3, 0, P + RD_LAT + 3);       // reset during second SHOW
        play(3, 0, 0);                    // replay from address 0 after reset

        for (int r = 0; r < 6; r++) begin
            int idle;
            for (int i = 0; i < 32; i++) mem[i] = 4'($urandom);
            idle = $urandom_range(0, 3);
            for (int c = 0; c < idle; c++) begin
                check("idle_busy",  c, 32'(busy),       32'd0);
                check("idle_valid", c, 32'(show_valid), 32'd0);
                check("idle_addr",  c, 32'(ram_addr),   32'd0);
                @(posedge clk); #1;
            end
            play($urandom_range(0, 40), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
